// File: rtl/mem_load_sched.sv
// In-order load scheduler: buffers issued loads and feeds the memory FU one at a time.
// Optional MEM_SCHED_BYPASS_EN: an empty, idle queue issues the enqueued load combinationally.
module mem_load_sched #(
  parameter int DEPTH    = 4,
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [TAG_W-1:0]         enq_rob_tag,
  input  logic [31:0]              enq_addr,
  input  logic [6:0]               enq_pd,
  input  logic                     fu_ready,
  input  logic                     fu_done,
  output logic                     issue_valid,
  output logic [TAG_W-1:0]         issue_rob_tag,
  output logic [31:0]              issue_addr,
  output logic [6:0]               issue_pd,
  input  logic [TAG_W-1:0]         curr_rob_tag,
  input  logic                     mispredict,
  input  logic [TAG_W-1:0]         mispredict_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = TAG_W + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [DEPTH-1:0] val_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [6:0]       pd_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       st_q, st_d;
  logic [TAG_W-1:0] infl_q, infl_d;
  logic             iv_q;
  logic [TAG_W-1:0] itag_q;
  logic [31:0]      iaddr_q;
  logic [6:0]       ipd_q;

  logic [AW-1:0]    lim;
  logic [DEPTH-1:0] sq_vec;
  logic             enq_sq, infl_sq;
  logic             enq_fire, nonempty, h_val, can_go;
  logic             byp, reg_enq, iss_head, pop_sq, wr, pop;

  // Squash window is (mispredict_tag, curr_rob_tag) modulo ROB_SIZE
  function automatic logic in_win(input logic [TAG_W-1:0] t,
                                  input logic [TAG_W-1:0] m,
                                  input logic [AW-1:0]    l);
    logic [AW-1:0] age;
    age = (AW'(t) + AW'(ROB_SIZE) - AW'(m)) % AW'(ROB_SIZE);
    return (age != '0) && (age < l);
  endfunction

  always_comb begin
    lim = (AW'(curr_rob_tag) + AW'(ROB_SIZE) - AW'(mispredict_tag))
          % AW'(ROB_SIZE);
    for (int i = 0; i < DEPTH; i++)
      sq_vec[i] = in_win(tag_q[i], mispredict_tag, lim);
    enq_sq  = in_win(enq_rob_tag, mispredict_tag, lim);
    infl_sq = in_win(infl_q, mispredict_tag, lim);
  end

  assign enq_ready = (cnt_q != CW'(DEPTH));
  assign count     = cnt_q;
  assign enq_fire  = enq_valid && enq_ready;
  assign nonempty  = (cnt_q != '0);
  assign h_val     = val_q[head_q];
  assign can_go    = !mispredict && fu_ready && (st_q == IDLE || fu_done);
  assign iss_head  = nonempty && h_val && can_go;
  assign pop_sq    = nonempty && !h_val && (st_q == IDLE) && !mispredict;
  assign pop       = iss_head || pop_sq;

`ifdef MEM_SCHED_BYPASS_EN
  assign byp     = !nonempty && (st_q == IDLE) && fu_ready && enq_valid && !mispredict;
  assign reg_enq = 1'b0;
  assign issue_valid   = iv_q || byp;
  assign issue_rob_tag = byp ? enq_rob_tag : itag_q;
  assign issue_addr    = byp ? enq_addr : iaddr_q;
  assign issue_pd      = byp ? enq_pd : ipd_q;
`else
  assign byp     = 1'b0;
  assign reg_enq = !nonempty && enq_fire && can_go;
  assign issue_valid   = iv_q;
  assign issue_rob_tag = itag_q;
  assign issue_addr    = iaddr_q;
  assign issue_pd      = ipd_q;
`endif

  assign wr    = enq_fire && !byp && !reg_enq;
  assign cnt_d = cnt_q + CW'(wr) - CW'(pop);

  always_comb begin
    st_d   = st_q;
    infl_d = infl_q;
    if (iss_head) begin
      st_d   = WAIT;
      infl_d = tag_q[head_q];
    end else if (reg_enq || byp) begin
      st_d   = WAIT;
      infl_d = enq_rob_tag;
    end else if (st_q == WAIT && (fu_done || (mispredict && infl_sq))) begin
      st_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      st_q    <= IDLE;
      infl_q  <= '0;
      iv_q    <= 1'b0;
      itag_q  <= '0;
      iaddr_q <= '0;
      ipd_q   <= '0;
    end else begin
      if (mispredict) val_q <= val_q & ~sq_vec;
      if (wr) begin
        val_q[tail_q] <= !(mispredict && enq_sq);
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      infl_q <= infl_d;
      iv_q   <= iss_head || reg_enq;
      if (iss_head) begin
        itag_q  <= tag_q[head_q];
        iaddr_q <= addr_q[head_q];
        ipd_q   <= pd_q[head_q];
      end else if (reg_enq) begin
        itag_q  <= enq_rob_tag;
        iaddr_q <= enq_addr;
        ipd_q   <= enq_pd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      tag_q[tail_q]  <= enq_rob_tag;
      addr_q[tail_q] <= enq_addr;
      pd_q[tail_q]   <= enq_pd;
    end
  end

endmodule
